// File: rtl/dmem_responder_if.sv
// Load/store request and response channels between the core MEM stage and the data RAM responder.
// Latency: n/a (wires only).  Backpressure: req_valid/req_ready and rsp_valid/rsp_ready handshakes.
// Optional behaviour is selected in the responder via DMEM_MISALIGN_TRAP_EN.
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: one RV32I load/store at a time against a word RAM; macro DMEM_MISALIGN_TRAP_EN traps misaligned accesses.
// Latency: response valid in the cycle after edge accept+WAIT_CYCLES.
// Backpressure: response held until rsp_ready; req_ready low whenever not IDLE.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  dmem_responder_if.slave bus,
  output logic            busy
);

  localparam int unsigned AW       = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN     = 33'(DEPTH_WORDS) << 2;
  localparam logic [3:0]  CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  typedef struct packed {
    logic        write;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  state_t      state;
  logic [3:0]  cnt;
  req_t        cap;
  req_t        live;
  req_t        acc;
  logic        accept;
  logic        do_access;
  logic        rsp_valid_q;
  logic [31:0] rsp_rdata_q;
  logic        rsp_err_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic [31:0]   offset;
  logic [1:0]    size;
  logic [1:0]    lane;
  logic          range_err;
  logic          f3_err;
  logic          align_err;
  logic          acc_err;
  logic [AW-1:0] word_idx;
  logic [31:0]   rd_word;
  logic [31:0]   rd_shift;
  logic [31:0]   ld_fmt;
  logic [31:0]   rdata_c;
  logic [3:0]    be;
  logic [31:0]   wd;
  logic          we;

  assign bus.req_ready = rst & (state == ST_IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign busy          = (state != ST_IDLE);

  assign accept = bus.req_valid & bus.req_ready;
  assign live   = {bus.req_write, bus.req_funct3, bus.req_addr, bus.req_wdata};

  // With zero wait states the access happens on the accept edge, so it must use the live request.
  assign acc = (state == ST_IDLE) ? live : cap;

  assign do_access = (state == ST_IDLE) ? (accept && (WAIT_CYCLES == 0))
                                        : (rst && (state == ST_WAIT) && (cnt == 4'd0));

  always_comb begin
    offset    = acc.addr - ADDR_BASE;
    size      = acc.funct3[1:0];
    range_err = ({1'b0, offset} >= SPAN);
    if (acc.write) begin
      f3_err = acc.funct3[2] || (size == 2'b11);
    end else begin
      f3_err = (size == 2'b11) || (acc.funct3 == 3'b110);
    end
`ifdef DMEM_MISALIGN_TRAP_EN
    align_err = ((size == 2'b01) && offset[0]) || ((size == 2'b10) && (offset[1:0] != 2'b00));
    lane      = offset[1:0];
`else
    align_err = 1'b0;
    case (size)
      2'b00:   lane = offset[1:0];
      2'b01:   lane = {offset[1], 1'b0};
      default: lane = 2'b00;
    endcase
`endif
    acc_err  = range_err | f3_err | align_err;
    word_idx = offset[AW+1:2];
    rd_word  = mem[word_idx];
  end

  always_comb begin
    rd_shift = rd_word >> {lane, 3'b000};
    case (size)
      2'b00:   ld_fmt = {{24{~acc.funct3[2] & rd_shift[7]}}, rd_shift[7:0]};
      2'b01:   ld_fmt = {{16{~acc.funct3[2] & rd_shift[15]}}, rd_shift[15:0]};
      default: ld_fmt = rd_word;
    endcase
    rdata_c = (acc.write || acc_err) ? 32'h0 : ld_fmt;
  end

  // Store data is replicated across lanes; byte enables pick the lanes that actually change.
  always_comb begin
    case (size)
      2'b00: begin
        be = 4'b0001 << lane;
        wd = {4{acc.wdata[7:0]}};
      end
      2'b01: begin
        be = 4'b0011 << lane;
        wd = {2{acc.wdata[15:0]}};
      end
      default: begin
        be = 4'b1111;
        wd = acc.wdata;
      end
    endcase
    we = do_access & acc.write & ~acc_err;
  end

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) begin
          mem[word_idx][b*8 +: 8] <= wd[b*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      cnt         <= 4'd0;
      cap         <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            cap <= live;
            if (WAIT_CYCLES == 0) begin
              state       <= ST_RESP;
              rsp_valid_q <= 1'b1;
              rsp_rdata_q <= rdata_c;
              rsp_err_q   <= acc_err;
            end else begin
              state <= ST_WAIT;
              cnt   <= CNT_INIT;
            end
          end
        end
        ST_WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            state       <= ST_RESP;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= rdata_c;
            rsp_err_q   <= acc_err;
          end
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            state       <= ST_IDLE;
            rsp_valid_q <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
